// File: rtl/bus_decoder_tracked_pkg.sv
// pkg_memorymap: slave address map, default target index and response-source type
// shared by the tracked bus decoder.
package pkg_memorymap;

    localparam int NumSlaves = 2;
    localparam int DefaultSlave = NumSlaves;

    // Ranges are half-open: [SlaveStart, SlaveEnd)
    localparam logic [63:0] SlaveStart [NumSlaves] = '{64'h0000_0000, 64'h0000_1000};
    localparam logic [63:0] SlaveEnd   [NumSlaves] = '{64'h0000_1000, 64'h0000_2000};

    typedef logic [$clog2(NumSlaves+1)-1:0] rsp_src_t;

    function automatic logic addr_hit(int idx, logic [63:0] addr);
        if (idx < 0 || idx >= NumSlaves) return 1'b0;
        return addr >= SlaveStart[idx] && addr < SlaveEnd[idx];
    endfunction

endpackage

// File: rtl/bus_decoder_tracked_fifo.sv
// bus_track_fifo: in-order FIFO of slave indices for accepted, unanswered transactions.
// A push is refused while full even if a pop happens in the same cycle.
module bus_track_fifo #(
    parameter int Width = 2,
    parameter int Depth = 4,
    localparam int PtrWidth = Depth > 1 ? $clog2(Depth) : 1,
    localparam int CntWidth = $clog2(Depth+1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [Width-1:0]    data_i,
    output logic [Width-1:0]    data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] count_o
);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr, rd_ptr;
    logic [CntWidth-1:0] count;
    logic                do_push, do_pop;

    function automatic logic [PtrWidth-1:0] next_ptr(logic [PtrWidth-1:0] p);
        return p == PtrWidth'(Depth-1) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = count == CntWidth'(Depth);
    assign empty_o = count == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];
    assign count_o = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CntWidth'(do_push) - CntWidth'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/bus_decoder_tracked.sv
// bus_decoder_tracked: range-table address decoder with in-order response steering.
// Define BUS_DECODER_ERR_SLAVE_EN to answer unmapped requests with a built-in error slave.
module bus_decoder_tracked
    import pkg_memorymap::*;
#(
    parameter int DWidth = 32,
    parameter int NumofSlave = DefaultSlave,
    parameter int MaxOutstanding = 4,
    localparam int MuxWidth = $clog2(NumofSlave+1),
    localparam int CntWidth = $clog2(MaxOutstanding+1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                m_req_i,
    input  logic [DWidth-1:0]   m_addr_i,
    output logic                m_gnt_o,
    output logic [NumofSlave:0] sel_o,
    input  logic [NumofSlave:0] s_gnt_i,
    input  logic [NumofSlave:0] s_rsp_valid_i,
    output logic [MuxWidth-1:0] rsp_mux_sel_o,
    output logic                rsp_valid_o,
    output logic                rsp_err_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                proto_err_o
);

    localparam int NumTargets = NumofSlave + 1;
    localparam logic [MuxWidth-1:0] DefIdx = MuxWidth'(NumofSlave);

    logic [63:0]           addr;
    logic [MuxWidth-1:0]   target, head;
    logic                  full, empty, target_gnt, head_rsp, is_err_head;
    logic [NumofSlave:0]   ext_mask, head_mask, stray;

    assign addr = 64'(m_addr_i);

    // Descending scan so the lowest matching index wins on overlap
    always_comb begin
        target = DefIdx;
        for (int i = NumofSlave - 1; i >= 0; i--)
            if (addr_hit(i, addr)) target = MuxWidth'(i);
    end

`ifdef BUS_DECODER_ERR_SLAVE_EN
    assign ext_mask    = {1'b0, {NumofSlave{1'b1}}};
    assign target_gnt  = target == DefIdx || s_gnt_i[target];
    assign is_err_head = !empty && head == DefIdx;
    assign head_rsp    = is_err_head || s_rsp_valid_i[head];
`else
    assign ext_mask    = '1;
    assign target_gnt  = s_gnt_i[target];
    assign is_err_head = 1'b0;
    assign head_rsp    = s_rsp_valid_i[head];
`endif

    assign sel_o         = ext_mask & (NumTargets'(m_req_i) << target);
    assign m_gnt_o       = m_req_i && target_gnt && !full;
    assign rsp_mux_sel_o = empty ? DefIdx : head;
    assign rsp_valid_o   = !empty && head_rsp;
    assign rsp_err_o     = rsp_valid_o && is_err_head;

    // Any external response not owned by the head entry is dropped and flagged
    assign head_mask = empty ? '0 : NumTargets'(1'b1) << head;
    assign stray     = s_rsp_valid_i & ext_mask & ~head_mask;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) proto_err_o <= 1'b0;
        else if (|stray) proto_err_o <= 1'b1;
    end

    bus_track_fifo #(
        .Width (MuxWidth),
        .Depth (MaxOutstanding)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (m_gnt_o),
        .pop_i   (rsp_valid_o),
        .data_i  (target),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_bus_decoder_tracked.sv
// tb_bus_decoder_tracked: directed checks of decode, grant, tracking FIFO and response steering.
// Expectations follow BUS_DECODER_ERR_SLAVE_EN when it is defined for the build.
module tb_bus_decoder_tracked;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_req = 1'b0;
    logic [31:0] m_addr = '0;
    logic        m_gnt;
    logic [2:0]  sel;
    logic [2:0]  s_gnt = '0;
    logic [2:0]  s_rsp_valid = '0;
    logic [1:0]  rsp_mux_sel;
    logic        rsp_valid, rsp_err, proto_err;
    logic [2:0]  outstanding;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    bus_decoder_tracked dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .m_req_i       (m_req),
        .m_addr_i      (m_addr),
        .m_gnt_o       (m_gnt),
        .sel_o         (sel),
        .s_gnt_i       (s_gnt),
        .s_rsp_valid_i (s_rsp_valid),
        .rsp_mux_sel_o (rsp_mux_sel),
        .rsp_valid_o   (rsp_valid),
        .rsp_err_o     (rsp_err),
        .outstanding_o (outstanding),
        .proto_err_o   (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b_addr [5] = '{32'h0000, 32'h0FFF, 32'h1000, 32'h1FFF, 32'h2000};
`ifdef BUS_DECODER_ERR_SLAVE_EN
    logic [2:0]  b_sel  [5] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b000};
`else
    logic [2:0]  b_sel  [5] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
`endif

    initial begin
        repeat (3) step();
        check("rst_outstanding", outstanding, 0);
        check("rst_mux_sel", rsp_mux_sel, 2);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_m_gnt", m_gnt, 0);
        check("idle_sel", sel, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            m_req = 1'b1;
            m_addr = b_addr[i];
            #1;
            check($sformatf("bound_sel_%0h", b_addr[i]), sel, b_sel[i]);
            m_req = 1'b0;
            step();
        end
        check("bound_no_push", outstanding, 0);

        // single transaction to S0
        m_req = 1'b1; m_addr = 32'h0800; s_gnt = 3'b001;
        #1;
        check("t1_sel", sel, 3'b001);
        check("t1_gnt", m_gnt, 1);
        step();
        m_req = 1'b0;
        check("t1_mux_sel", rsp_mux_sel, 0);
        check("t1_outstanding", outstanding, 1);
        check("t1_no_rsp_yet", rsp_valid, 0);
        s_rsp_valid = 3'b001;
        #1;
        check("t1_rsp_valid", rsp_valid, 1);
        step();
        s_rsp_valid = 3'b000;
        check("t1_outstanding_done", outstanding, 0);
        check("t1_mux_sel_empty", rsp_mux_sel, 2);

        // S0, S1, S0 back to back, S1 answers out of order
        s_gnt = 3'b011; m_req = 1'b1;
        m_addr = 32'h0010; step();
        m_addr = 32'h1004; step();
        m_addr = 32'h0020; step();
        m_req = 1'b0;
        check("t2_outstanding", outstanding, 3);
        s_rsp_valid = 3'b010;
        #1;
        check("t2_stray_ignored", rsp_valid, 0);
        step();
        check("t2_proto_err", proto_err, 1);
        check("t2_outstanding_kept", outstanding, 3);
        s_rsp_valid = 3'b001;
        #1;
        check("t2_rsp0", rsp_valid, 1);
        step();
        check("t2_head1", rsp_mux_sel, 1);
        s_rsp_valid = 3'b010;
        #1;
        check("t2_rsp1", rsp_valid, 1);
        step();
        check("t2_head0", rsp_mux_sel, 0);
        s_rsp_valid = 3'b001;
        #1;
        check("t2_rsp2", rsp_valid, 1);
        step();
        s_rsp_valid = 3'b000;
        check("t2_drained", outstanding, 0);

        // fill the FIFO, then pop and push in the same cycle
        s_gnt = 3'b001; m_req = 1'b1; m_addr = 32'h0100;
        repeat (4) step();
        check("t3_full_count", outstanding, 4);
        #1;
        check("t3_full_gnt", m_gnt, 0);
        s_rsp_valid = 3'b001;
        #1;
        check("t3_pop_valid", rsp_valid, 1);
        check("t3_pop_push_gnt", m_gnt, 0);
        step();
        m_req = 1'b0; s_rsp_valid = 3'b000;
        check("t3_after_pop", outstanding, 3);

        // ungranted request to S1
        m_req = 1'b1; m_addr = 32'h1004; s_gnt = 3'b001;
        #1;
        check("t6_gnt", m_gnt, 0);
        check("t6_sel", sel, 3'b010);
        step();
        m_req = 1'b0;
        check("t6_no_push", outstanding, 3);

        // asynchronous reset with transactions in flight
        rst_n = 1'b0;
        #1;
        check("t5_rst_outstanding", outstanding, 0);
        check("t5_rst_mux_sel", rsp_mux_sel, 2);
        check("t5_rst_proto", proto_err, 0);
        step();
        rst_n = 1'b1;
        step();
        s_rsp_valid = 3'b001;
        #1;
        check("t5_lost_rsp", rsp_valid, 0);
        step();
        s_rsp_valid = 3'b000;
        check("t5_proto_err", proto_err, 1);

        // unmapped address
        m_req = 1'b1; m_addr = 32'h3000;
`ifdef BUS_DECODER_ERR_SLAVE_EN
        s_gnt = 3'b000;
        #1;
        check("t4_sel", sel, 3'b000);
        check("t4_gnt", m_gnt, 1);
        step();
        m_req = 1'b0;
        #1;
        check("t4_err_valid", rsp_valid, 1);
        check("t4_err_flag", rsp_err, 1);
        step();
        check("t4_drained", outstanding, 0);
`else
        s_gnt = 3'b100;
        #1;
        check("t4_sel", sel, 3'b100);
        check("t4_gnt", m_gnt, 1);
        step();
        m_req = 1'b0;
        check("t4_mux_sel", rsp_mux_sel, 2);
        check("t4_outstanding", outstanding, 1);
        check("t4_waits", rsp_valid, 0);
        s_rsp_valid = 3'b100;
        #1;
        check("t4_default_valid", rsp_valid, 1);
        check("t4_no_err", rsp_err, 0);
        step();
        s_rsp_valid = 3'b000;
        check("t4_drained", outstanding, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
